imem_loader: RTL and testbench

- Byte-stream writer that fills the CPU instruction memory at run time, so programs no longer need to be baked in at synthesis.
- Takes bytes from a serial receiver over a valid/ready handshake and packs them into 32-bit little-endian words.
- Issues one-cycle write strobes into the 1024 x 32 instruction RAM at consecutive word addresses.
- Holds the CPU in reset while loading is in progress.

---
 rtl/imem_loader.sv | 170 +++++++++++++++++
 tb/tb_imem_loader.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// Byte-stream instruction-memory loader: reads a 16-bit little-endian word count, then
// packs little-endian bytes into 32-bit words and strobes them into the instruction RAM.
module imem_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 32,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic              cpu_hold,
    output logic [ADDR_W:0]   words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;
    localparam logic [2:0] S_ERR    = 3'd5;

    localparam logic [15:0]     MAX_LEN = 16'(MAX_WORDS);
    localparam logic [ADDR_W:0] WL_ONE  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] WI_ONE = ADDR_W'(1);

    logic [2:0]        state_q,    state_d;
    logic [15:0]       len_q,      len_d;
    logic [1:0]        lane_q,     lane_d;
    logic [DATA_W-9:0] pack_q,     pack_d;
    logic [ADDR_W-1:0] word_idx_q, word_idx_d;
    logic [ADDR_W:0]   wl_q,       wl_d;
    logic              we_q,       we_d;
    logic [ADDR_W-1:0] waddr_q,    waddr_d;
    logic [DATA_W-1:0] wdata_q,    wdata_d;
    logic              done_q,     done_d;
    logic              error_q,    error_d;
    logic              hold_q,     hold_d;

    logic              accept;
    logic [15:0]       len_full;
    logic [ADDR_W:0]   wl_inc;

    assign in_ready = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) || (state_q == S_DATA);
    assign busy     = in_ready;
    assign accept   = in_valid && in_ready;
    assign len_full = {in_data, len_q[7:0]};
    assign wl_inc   = wl_q + WL_ONE;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        lane_d     = lane_q;
        pack_d     = pack_q;
        word_idx_d = word_idx_q;
        wl_d       = wl_q;
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        done_d     = done_q;
        error_d    = error_q;
        hold_d     = hold_q;

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    state_d    = S_LEN_LO;
                    len_d      = 16'd0;
                    lane_d     = 2'd0;
                    word_idx_d = '0;
                    wl_d       = '0;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    hold_d     = 1'b1;
                end
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    // A zero-length or oversized program is refused; the CPU stays held.
                    if (len_full == 16'd0 || len_full > MAX_LEN) begin
                        state_d = S_ERR;
                        error_d = 1'b1;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept) begin
                    lane_d = lane_q + 2'd1;
                    case (lane_q)
                        2'd0: pack_d[7:0]   = in_data;
                        2'd1: pack_d[15:8]  = in_data;
                        2'd2: pack_d[23:16] = in_data;
                        default: begin
                            we_d       = 1'b1;
                            waddr_d    = word_idx_q;
                            wdata_d    = {in_data, pack_q};
                            word_idx_d = word_idx_q + WI_ONE;
                            wl_d       = wl_inc;
                            if (wl_inc == len_q[ADDR_W:0]) begin
                                state_d = S_DONE;
                                done_d  = 1'b1;
                                hold_d  = 1'b0;
                            end
                        end
                    endcase
                end
            end
            default: begin
                state_d = S_IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            len_q      <= 16'd0;
            lane_q     <= 2'd0;
            pack_q     <= '0;
            word_idx_q <= '0;
            wl_q       <= '0;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            lane_q     <= lane_d;
            pack_q     <= pack_d;
            word_idx_q <= word_idx_d;
            wl_q       <= wl_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            done_q     <= done_d;
            error_q    <= error_d;
            hold_q     <= hold_d;
        end
    end

    assign we           = we_q;
    assign waddr        = waddr_q;
    assign wdata        = wdata_q;
    assign done         = done_q;
    assign error        = error_q;
    assign cpu_hold     = hold_q;
    assign words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: every RAM write is logged and compared with hand-computed words.
module tb_imem_loader;
    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic              busy;
    logic              done;
    logic              error;
    logic              cpu_hold;
    logic [ADDR_W:0]   words_loaded;

    int total = 0;
    int bad   = 0;

    logic [ADDR_W-1:0] wa_q[$];
    logic [DATA_W-1:0] wd_q[$];

    imem_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WORDS(1024)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .we(we), .waddr(waddr), .wdata(wdata), .busy(busy),
        .done(done), .error(error), .cpu_hold(cpu_hold), .words_loaded(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (we === 1'b1) begin
            wa_q.push_back(waddr);
            wd_q.push_back(wdata);
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        @(negedge clk);
        start    = 1'b0;
        in_valid = 1'b1;
        in_data  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        total++;
        if (in_ready !== 1'b1) begin
            bad++;
            $display("FAIL send_byte_timeout in_ready=%b required=1 byte=%h", in_ready, b);
        end
        @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            start    = 1'b0;
        end
        #1;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        in_valid = 1'b0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if ({we, busy, done, error, cpu_hold, in_ready} !== 6'b0) begin
            bad++;
            $display("FAIL reset_flags got=%b required=000000", {we, busy, done, error, cpu_hold, in_ready});
        end
        total++;
        if ({waddr, wdata, words_loaded} !== '0) begin
            bad++;
            $display("FAIL reset_buses waddr=%h wdata=%h wl=%0d required=0", waddr, wdata, words_loaded);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(1);
    endtask

    task automatic test_idle();
        int rdy_seen;
        wa_q.delete(); wd_q.delete();
        rdy_seen = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b0) rdy_seen++;
        end
        total++;
        if (rdy_seen != 0) begin
            bad++;
            $display("FAIL idle_in_ready cycles_high=%0d required=0", rdy_seen);
        end
        total++;
        if ({busy, cpu_hold, done, error} !== 4'b0) begin
            bad++;
            $display("FAIL idle_state got=%b required=0000", {busy, cpu_hold, done, error});
        end
        total++;
        if (wa_q.size() != 0) begin
            bad++;
            $display("FAIL idle_writes got=%0d required=0", wa_q.size());
        end
        idle_cycles(1);
    endtask

    task automatic test_basic();
        logic [7:0] bytes [10] = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        total++;
        if ({cpu_hold, busy, in_ready} !== 3'b111) begin
            bad++;
            $display("FAIL basic_session_open got=%b required=111", {cpu_hold, busy, in_ready});
        end
        for (int i = 0; i < 10; i++) send_byte(bytes[i]);
        idle_cycles(2);
        total++;
        if (wa_q.size() != 2) begin
            bad++;
            $display("FAIL basic_write_count got=%0d required=2", wa_q.size());
        end else begin
            total++;
            if (wa_q[0] !== 10'd0 || wd_q[0] !== 32'h00000013) begin
                bad++;
                $display("FAIL basic_word0 addr=%h data=%h required 000/00000013", wa_q[0], wd_q[0]);
            end
            total++;
            if (wa_q[1] !== 10'd1 || wd_q[1] !== 32'h00100093) begin
                bad++;
                $display("FAIL basic_word1 addr=%h data=%h required 001/00100093", wa_q[1], wd_q[1]);
            end
        end
        total++;
        if ({done, error, cpu_hold, in_ready, busy} !== 5'b10000) begin
            bad++;
            $display("FAIL basic_end_flags got=%b required=10000", {done, error, cpu_hold, in_ready, busy});
        end
        total++;
        if (words_loaded !== 11'd2) begin
            bad++;
            $display("FAIL basic_words_loaded got=%0d required=2", words_loaded);
        end
    endtask

    task automatic test_err();
        logic [7:0] good [6] = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        total++;
        if ({done, error, words_loaded} !== '0) begin
            bad++;
            $display("FAIL err_start_clears done=%b error=%b wl=%0d required=0", done, error, words_loaded);
        end
        send_byte(8'h00); send_byte(8'h00);
        idle_cycles(2);
        total++;
        if ({error, cpu_hold, done, busy, in_ready} !== 5'b11000) begin
            bad++;
            $display("FAIL err_len0 got=%b required=11000", {error, cpu_hold, done, busy, in_ready});
        end
        pulse_start();
        total++;
        if (error !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++;
            $display("FAIL err_restart error=%b hold=%b required 0/1", error, cpu_hold);
        end
        send_byte(8'h01); send_byte(8'h04);
        idle_cycles(2);
        total++;
        if ({error, cpu_hold, done} !== 3'b110) begin
            bad++;
            $display("FAIL err_len1025 got=%b required=110", {error, cpu_hold, done});
        end
        total++;
        if (wa_q.size() != 0) begin
            bad++;
            $display("FAIL err_no_write got=%0d required=0", wa_q.size());
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(good[i]);
        idle_cycles(2);
        total++;
        if (wa_q.size() != 1 || wa_q[0] !== 10'd0 || wd_q[0] !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL err_recover_write count=%0d addr=%h data=%h required 1/000/DEADBEEF",
                     wa_q.size(), (wa_q.size() > 0) ? wa_q[0] : 10'h0, (wd_q.size() > 0) ? wd_q[0] : 32'h0);
        end
        total++;
        if ({error, done, cpu_hold} !== 3'b010 || words_loaded !== 11'd1) begin
            bad++;
            $display("FAIL err_recover_flags edc=%b wl=%0d required 010/1", {error, done, cpu_hold}, words_loaded);
        end
    endtask

    task automatic test_full();
        int wrong;
        logic [15:0] iv;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        send_byte(8'h00); send_byte(8'h04);
        for (int i = 0; i < 1024; i++) begin
            iv = 16'(i);
            send_byte(iv[7:0]); send_byte(iv[15:8]); send_byte(8'h00); send_byte(8'h00);
        end
        idle_cycles(2);
        total++;
        if (wa_q.size() != 1024) begin
            bad++;
            $display("FAIL full_write_count got=%0d required=1024", wa_q.size());
        end else begin
            wrong = 0;
            for (int i = 0; i < 1024; i++)
                if (wa_q[i] !== 10'(i) || wd_q[i] !== 32'(i)) wrong++;
            total++;
            if (wrong != 0) begin
                bad++;
                $display("FAIL full_contents wrong_words=%0d required=0", wrong);
            end
            total++;
            if (wa_q[1023] !== 10'h3FF || wd_q[1023] !== 32'h000003FF) begin
                bad++;
                $display("FAIL full_last addr=%h data=%h required 3FF/000003FF", wa_q[1023], wd_q[1023]);
            end
        end
        total++;
        if (words_loaded !== 11'd1024 || done !== 1'b1 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL full_end wl=%0d done=%b hold=%b required 1024/1/0", words_loaded, done, cpu_hold);
        end
    endtask

    task automatic test_gaps();
        logic [7:0]  bytes [14] = '{8'h03, 8'h00, 8'hD4, 8'hC3, 8'hB2, 8'hA1, 8'h04, 8'h03,
                                    8'h02, 8'h01, 8'h0D, 8'hF0, 8'hFE, 8'hCA};
        logic [31:0] exp_w [3] = '{32'hA1B2C3D4, 32'h01020304, 32'hCAFEF00D};
        int g;
        int wrong;
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int k = 0; k < 14; k++) begin
            g = int'($urandom_range(0, 5));
            if (k == 1 || k == 5 || k == 9) g = (g == 0) ? 1 : g;
            for (int j = 0; j < g; j++) begin
                @(negedge clk);
                in_valid = 1'b0;
                start    = (j == 0);
            end
            send_byte(bytes[k]);
        end
        idle_cycles(2);
        total++;
        if (wa_q.size() != 3) begin
            bad++;
            $display("FAIL gaps_write_count got=%0d required=3", wa_q.size());
        end else begin
            wrong = 0;
            for (int i = 0; i < 3; i++)
                if (wa_q[i] !== 10'(i) || wd_q[i] !== exp_w[i]) wrong++;
            total++;
            if (wrong != 0) begin
                bad++;
                $display("FAIL gaps_contents wrong_words=%0d w0=%h required=0 (A1B2C3D4)", wrong, wd_q[0]);
            end
        end
        total++;
        if (done !== 1'b1 || words_loaded !== 11'd3) begin
            bad++;
            $display("FAIL gaps_end done=%b wl=%0d required 1/3", done, words_loaded);
        end
    endtask

    task automatic test_midreset();
        logic [7:0] part [8] = '{8'h03, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        logic [7:0] fresh [6] = '{8'h01, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12};
        wa_q.delete(); wd_q.delete();
        pulse_start();
        for (int i = 0; i < 8; i++) send_byte(part[i]);
        @(negedge clk);
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        total++;
        if ({we, busy, done, error, cpu_hold, in_ready} !== 6'b0 ||
            {waddr, wdata, words_loaded} !== '0) begin
            bad++;
            $display("FAIL midreset_outputs flags=%b waddr=%h wdata=%h wl=%0d required all 0",
                     {we, busy, done, error, cpu_hold, in_ready}, waddr, wdata, words_loaded);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_cycles(3);
        total++;
        if (wa_q.size() != 1 || busy !== 1'b0 || cpu_hold !== 1'b0) begin
            bad++;
            $display("FAIL midreset_aborted writes=%0d busy=%b hold=%b required 1/0/0",
                     wa_q.size(), busy, cpu_hold);
        end
        pulse_start();
        for (int i = 0; i < 6; i++) send_byte(fresh[i]);
        idle_cycles(2);
        total++;
        if (wa_q.size() != 2 || wa_q[wa_q.size()-1] !== 10'd0 || wd_q[wd_q.size()-1] !== 32'h12345678) begin
            bad++;
            $display("FAIL midreset_fresh writes=%0d last_addr=%h last_data=%h required 2/000/12345678",
                     wa_q.size(), wa_q[wa_q.size()-1], wd_q[wd_q.size()-1]);
        end
        total++;
        if (done !== 1'b1 || words_loaded !== 11'd1) begin
            bad++;
            $display("FAIL midreset_fresh_end done=%b wl=%0d required 1/1", done, words_loaded);
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_basic();
        test_err();
        test_full();
        test_gaps();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout reached required=finish");
        $fatal(1);
    end
endmodule
